// File: rtl/pkt_wr_dma.sv
// Avalon-MM burst write master: drains one packet per start from a show-ahead FIFO into a ring buffer.
// Optional per-packet length header beat is enabled by defining PKT_WR_DMA_LEN_HDR_EN.
module pkt_wr_dma #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  localparam int BYTES    = DATA_W / 8,
  localparam int BC_W     = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       pkt_len,
  input  logic [ADDR_W-1:0] buf_base,
  input  logic [ADDR_W-1:0] buf_size,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] address,
  output logic [BC_W-1:0]   burstcount,
  output logic [DATA_W-1:0] writedata,
  output logic [BYTES-1:0]  byteenable,
  output logic              write,
  input  logic              waitrequest
);
  localparam int LB = $clog2(BYTES);
  localparam int CW = (ADDR_W > 17) ? ADDR_W : 17;

  typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} state_t;
  state_t state, state_nxt;

  logic [16:0]       rem;
  logic [16:0]       words;
  logic [LB-1:0]     tail;
  logic [ADDR_W-1:0] wr_ptr_work;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] space;
  logic [BC_W-1:0]   beat;
  logic [BC_W-1:0]   blen;
  logic              hdr_beat;
  logic [DATA_W-1:0] hdr_data;
  logic              accept;
  logic              last_in_burst;

`ifdef PKT_WR_DMA_LEN_HDR_EN
  logic        hdr_pend;
  logic [15:0] len_q;

  assign words = 17'(({1'b0, pkt_len} + 17'(BYTES - 1)) >> LB) + 17'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hdr_pend <= 1'b0;
      len_q    <= '0;
    end else if (state == IDLE && start) begin
      hdr_pend <= 1'b1;
      len_q    <= pkt_len;
    end else if (accept) begin
      hdr_pend <= 1'b0;
    end
  end

  assign hdr_beat = (state == BURST) && hdr_pend;
  assign hdr_data = DATA_W'(len_q);
`else
  assign words    = 17'(({1'b0, pkt_len} + 17'(BYTES - 1)) >> LB);
  assign hdr_beat = 1'b0;
  assign hdr_data = '0;
`endif

  // Room left before the ring end, in beats; bursts are clipped so they never wrap.
  assign space   = (buf_size - wr_ptr_work) >> LB;
  assign ptr_inc = wr_ptr_work + ADDR_W'(BYTES);
  assign ptr_nxt = (ptr_inc == buf_size) ? '0 : ptr_inc;

  always_comb begin
    blen = BC_W'(MAX_BURST);
    if (CW'(rem) < CW'(MAX_BURST)) blen = BC_W'(rem);
    if (CW'(space) < CW'(blen)) blen = BC_W'(space);
  end

  assign last_in_burst = (beat == burstcount - BC_W'(1));
  assign accept        = write && !waitrequest;

  always_comb begin
    state_nxt  = state;
    write      = 1'b0;
    fifo_rd    = 1'b0;
    writedata  = '0;
    byteenable = '1;
    busy       = (state != IDLE);
    done       = (state == DONE);
    err        = start && (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (words == 17'd0) ? DONE : SETUP;
      end
      SETUP: begin
        state_nxt = BURST;
      end
      BURST: begin
        write     = hdr_beat || !fifo_empty;
        fifo_rd   = write && !waitrequest && !hdr_beat;
        writedata = hdr_beat ? hdr_data : fifo_data;
        if (!hdr_beat && rem == 17'd1 && tail != '0)
          byteenable = ~({BYTES{1'b1}} << tail);
        if (write && !waitrequest && last_in_burst)
          state_nxt = (rem == 17'd1) ? DONE : SETUP;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rem         <= '0;
      tail        <= '0;
      wr_ptr      <= '0;
      wr_ptr_work <= '0;
      address     <= '0;
      burstcount  <= '0;
      beat        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            rem         <= words;
            tail        <= pkt_len[LB-1:0];
            wr_ptr_work <= wr_ptr;
          end
        end
        SETUP: begin
          address    <= buf_base + wr_ptr_work;
          burstcount <= blen;
          beat       <= '0;
        end
        BURST: begin
          if (accept) begin
            beat        <= beat + BC_W'(1);
            rem         <= rem - 17'd1;
            wr_ptr_work <= ptr_nxt;
          end
        end
        DONE: begin
          wr_ptr <= wr_ptr_work;
        end
        default: ;
      endcase
    end
  end

endmodule
